// File: rtl/decode_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// decode_frame_scheduler_if
//
// Handshake bundle between the frame scheduler and the blocks it sequences:
// the input FIFO status, the load FSM, the decode core, the output FIFO
// status and the unload FSM.
//
// Signals:
//   frame_avail   input FIFO holds a complete codeword (level)
//   load_start    one-cycle pulse that starts the load FSM
//   load_done     load complete; the rising edge is the event (level)
//   dec_start     one-cycle pulse that starts one decode iteration
//   iter_done     one-cycle pulse; the decode iteration has finished
//   syndrome_ok   all parity checks satisfied; valid with iter_done
//   out_ready     output FIFO can accept a full codeword (level)
//   unload_start  one-cycle pulse that starts the unload FSM
//   unload_done   unload complete; the rising edge is the event (level)
//
// Modports:
//   master  the scheduler side (drives the start pulses)
//   slave   the side of the FIFOs and the load/decode/unload blocks
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface decode_frame_scheduler_if;

    logic frame_avail;
    logic load_start;
    logic load_done;
    logic dec_start;
    logic iter_done;
    logic syndrome_ok;
    logic out_ready;
    logic unload_start;
    logic unload_done;

    modport master (
        input  frame_avail,
        input  load_done,
        input  iter_done,
        input  syndrome_ok,
        input  out_ready,
        input  unload_done,
        output load_start,
        output dec_start,
        output unload_start
    );

    modport slave (
        output frame_avail,
        output load_done,
        output iter_done,
        output syndrome_ok,
        output out_ready,
        output unload_done,
        input  load_start,
        input  dec_start,
        input  unload_start
    );

endinterface

// File: rtl/decode_frame_scheduler.sv
// -----------------------------------------------------------------------------
// decode_frame_scheduler
//
// Top-level sequencer for one codeword through an iterative decoder:
// load from the input FIFO, run up to MAXITER decode iterations, wait for
// space downstream, then unload. Status and error flags are exposed.
//
// Parameters:
//   MAXITER  maximum decode iterations per frame (1 .. 2^ITERW-1)
//   ITERW    width of the iteration counters
//   FRAMEW   width of the finished-frame counter (wraps)
//   WDOGW    watchdog width; a wait state times out after 2^WDOGW-1 cycles
//
// Build option:
//   EARLY_TERM_EN  when defined, an iteration reporting syndrome_ok ends the
//                  decode at once; otherwise every frame runs MAXITER
//                  iterations and syndrome_ok only feeds 'converged'.
//
// Ports:
//   clk          decode clock
//   rst          synchronous, active-low reset
//   bus          handshake bundle (master modport)
//   busy         scheduler is not idle
//   iter_count   iterations completed in the current frame
//   last_iters   iterations used by the last finished frame
//   converged    last finished frame ended with syndrome_ok
//   frame_done   one-cycle pulse per finished frame
//   frame_count  finished frames, modulo 2^FRAMEW
//   wdog_err     sticky; a wait state timed out
//
// Every output is a flop. The start pulses and busy are registered copies of
// the state, so each pulse appears the cycle after its request state.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module decode_frame_scheduler #(
    parameter int MAXITER = 10,
    parameter int ITERW   = 5,
    parameter int FRAMEW  = 16,
    parameter int WDOGW   = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    decode_frame_scheduler_if.master      bus,
    output logic                          busy,
    output logic [ITERW-1:0]              iter_count,
    output logic [ITERW-1:0]              last_iters,
    output logic                          converged,
    output logic                          frame_done,
    output logic [FRAMEW-1:0]             frame_count,
    output logic                          wdog_err
);

    localparam logic [ITERW-1:0] MAX_ITER_W = ITERW'(MAXITER);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_REQ,
        S_LOAD_WAIT,
        S_DEC_START,
        S_DEC_RUN,
        S_UNLOAD_WAIT,
        S_UNLOAD_REQ,
        S_UNLOAD_RUN,
        S_FINISH
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               load_done_q;
    logic               unload_done_q;
    logic               load_rise;
    logic               unload_rise;

    logic [WDOGW-1:0]   wdog_cnt;
    logic               wdog_full;
    logic               watched;
    logic               wdog_clr;
    logic               timeout;

    logic [ITERW-1:0]   iter_inc;
    logic [ITERW-1:0]   iter_next;
    logic               capture;
    logic               early_term;

    // Only a 0->1 transition of the done levels is an event; a level held
    // high across several cycles must not re-trigger.
    assign load_rise   = bus.load_done   & ~load_done_q;
    assign unload_rise = bus.unload_done & ~unload_done_q;

    assign wdog_full   = &wdog_cnt;

`ifdef EARLY_TERM_EN
    assign early_term = bus.syndrome_ok;
`else
    assign early_term = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next = state;
        iter_next  = iter_count;
        capture    = 1'b0;
        timeout    = 1'b0;
        wdog_clr   = 1'b0;
        watched    = 1'b0;

        // Saturating increment; the exit test below keeps it from ever being
        // needed, but the counter can never wrap past MAXITER.
        iter_inc = (iter_count == MAX_ITER_W) ? iter_count : iter_count + 1'b1;

        case (state)
            S_IDLE: begin
                if (bus.frame_avail) begin
                    state_next = S_LOAD_REQ;
                end
            end

            S_LOAD_REQ: begin
                state_next = S_LOAD_WAIT;
            end

            S_LOAD_WAIT: begin
                watched = 1'b1;
                if (load_rise) begin
                    state_next = S_DEC_START;
                    iter_next  = '0;
                end else if (wdog_full) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end

            S_DEC_START: begin
                state_next = S_DEC_RUN;
            end

            S_DEC_RUN: begin
                watched = 1'b1;
                if (bus.iter_done) begin
                    // A finished iteration wins over a watchdog expiry in the
                    // same cycle: the core did respond in time.
                    iter_next = iter_inc;
                    wdog_clr  = 1'b1;
                    if ((iter_inc == MAX_ITER_W) || early_term) begin
                        capture    = 1'b1;
                        state_next = S_UNLOAD_WAIT;
                    end else begin
                        state_next = S_DEC_START;
                    end
                end else if (wdog_full) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end

            // Downstream backpressure may last indefinitely, so this wait is
            // deliberately not covered by the watchdog.
            S_UNLOAD_WAIT: begin
                if (bus.out_ready) begin
                    state_next = S_UNLOAD_REQ;
                end
            end

            S_UNLOAD_REQ: begin
                state_next = S_UNLOAD_RUN;
            end

            S_UNLOAD_RUN: begin
                watched = 1'b1;
                if (unload_rise) begin
                    state_next = S_FINISH;
                end else if (wdog_full) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end

            S_FINISH: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register, edge-detect history and watchdog
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and active-low; every flop in the
        // block, including the status outputs, returns to zero here so a
        // frame in flight is abandoned without emitting any pulse.
        if (!rst) begin
            state         <= S_IDLE;
            load_done_q   <= 1'b0;
            unload_done_q <= 1'b0;
            wdog_cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments for all clocked state, so every
            // flop samples the values from before this edge.
            state         <= state_next;
            load_done_q   <= bus.load_done;
            unload_done_q <= bus.unload_done;
            // Counter restarts on entry to any state and on each finished
            // iteration; it only runs while sitting in a watched state.
            if (wdog_clr || (state_next != state) || !watched) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.load_start   <= 1'b0;
            bus.dec_start    <= 1'b0;
            bus.unload_start <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            iter_count       <= '0;
            last_iters       <= '0;
            converged        <= 1'b0;
            frame_count      <= '0;
            wdog_err         <= 1'b0;
        end else begin
            bus.load_start   <= (state == S_LOAD_REQ);
            bus.dec_start    <= (state == S_DEC_START);
            bus.unload_start <= (state == S_UNLOAD_REQ);
            busy             <= (state != S_IDLE);
            frame_done       <= (state == S_FINISH);
            iter_count       <= iter_next;

            if (capture) begin
                last_iters <= iter_inc;
                converged  <= bus.syndrome_ok;
            end

            // A timed-out frame never reaches FINISH, so it is not counted.
            if (state == S_FINISH) begin
                frame_count <= frame_count + 1'b1;
            end

            if (timeout) begin
                wdog_err <= 1'b1;
            end
        end
    end

endmodule
